// File: rtl/if_fetch_stage.sv
// if_fetch_stage: program counter plus a single-outstanding instruction memory fetch,
// presenting (pc + step, instruction) downstream over valid/ready with redirect and freeze.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        freeze,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] output_pc,
    output logic [31:0] output_instruction_memory
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, opc_q, opc_d, ins_q, ins_d, pc_next;
    logic        kill_q, kill_d, valid_q, valid_d;

    assign pc_next = pc_q + PC_STEP;
    assign imem_req = rst && !freeze && !branch_taken &&
                      (state_q == S_REQ || (state_q == S_HOLD && out_ready));
    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign output_pc = opc_q;
    assign output_instruction_memory = ins_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        ins_d   = ins_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        case (state_q)
            S_REQ: begin
                if (branch_taken) pc_d = branch_addr;
                else if (imem_req) state_d = S_WAIT;
            end
            S_WAIT: begin
                // kill marks the outstanding response as belonging to a redirected-away path
                if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (branch_taken) begin
                        pc_d    = branch_addr;
                        state_d = S_REQ;
                    end else begin
                        ins_d   = imem_rdata;
                        opc_d   = pc_next;
                        pc_d    = pc_next;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (branch_taken) begin
                    kill_d = 1'b1;
                    pc_d   = branch_addr;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    pc_d    = branch_addr;
                    state_d = S_REQ;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = imem_req ? S_WAIT : S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            opc_q   <= 32'd0;
            ins_q   <= 32'd0;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            ins_q   <= ins_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and random fetch traffic checked against a transaction-level
// model of the fetch stream (next fetch address, stale-response flag, queue of expected outputs).
module tb_if_fetch_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } pair_t;

    logic        clk, rst;
    logic        branch_taken, freeze, imem_rsp_valid, out_ready;
    logic [31:0] branch_addr, imem_rdata;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, output_pc, output_instruction_memory;

    logic        rsp2, imem_req2, out_valid2;
    logic [31:0] imem_addr2, output_pc2, ins2;

    int          n_cmp = 0, n_err = 0;
    pair_t       q[$];
    logic [31:0] model_pc, maddr, last_addr;
    logic        busy, stale, last_req, req2_prev;
    int          cnt, lat;

    if_fetch_stage u_dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .freeze(freeze), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .output_pc(output_pc),
        .output_instruction_memory(output_instruction_memory)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .branch_taken(1'b0), .branch_addr(32'd0),
        .freeze(1'b0), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rsp_valid(rsp2), .imem_rdata(32'h1234_5678), .out_valid(out_valid2),
        .out_ready(1'b1), .output_pc(output_pc2), .output_instruction_memory(ins2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0001 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        model_pc  = 32'd0;
        busy      = 1'b0;
        stale     = 1'b0;
        cnt       = 0;
        req2_prev = 1'b0;
        rsp2      = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, advance the model, return at posedge+1.
    task automatic cyc(input logic br, input logic [31:0] ba, input logic fr, input logic rdy);
        logic exp_req;
        @(negedge clk);
        imem_rsp_valid = busy && cnt == 0;
        imem_rdata     = imem_rsp_valid ? mem_word(maddr) : 32'hDEAD_BEEF;
        branch_taken   = br && !(imem_rsp_valid && stale);
        branch_addr    = ba;
        freeze         = fr;
        out_ready      = rdy;
        rsp2           = req2_prev;
        #1;
        exp_req = !freeze && !branch_taken && !busy && (q.size() == 0 || out_ready);
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_pc", output_pc, q[0].pc);
            chk("out_ins", output_instruction_memory, q[0].ins);
        end
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, model_pc);
        last_req  = imem_req;
        last_addr = imem_addr;
        req2_prev = imem_req2;
        if (q.size() != 0 && (out_ready || branch_taken)) void'(q.pop_front());
        if (imem_rsp_valid) begin
            busy = 1'b0;
            if (!stale && !branch_taken) begin
                q.push_back('{maddr + 32'd4, mem_word(maddr)});
                model_pc = maddr + 32'd4;
            end
        end else if (busy) begin
            if (branch_taken) stale = 1'b1;
            cnt--;
        end
        if (branch_taken) model_pc = branch_addr;
        if (imem_req) begin
            busy  = 1'b1;
            maddr = imem_addr;
            cnt   = lat;
            stale = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; freeze = 1'b0;
        imem_rsp_valid = 1'b0; imem_rdata = 32'd0; out_ready = 1'b0;
        last_req = 1'b0; last_addr = 32'd0; maddr = 32'd0; lat = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", output_pc, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        rst = 1'b1;

        // sequential fetch with 1-cycle memory, plus wraparound instance
        cyc(0, 0, 0, 1);
        chk("t1_req0", {31'd0, last_req}, 32'd1);
        chk("t1_addr0", last_addr, 32'd0);
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1);
        chk("t1_pc0", output_pc, 32'd4);
        chk("t1_ins0", output_instruction_memory, 32'hE000_0001);
        chk("wrap_valid", {31'd0, out_valid2}, 32'd1);
        chk("wrap_pc", output_pc2, 32'd0);
        chk("wrap_ins", ins2, 32'h1234_5678);
        chk("wrap_next", imem_addr2, 32'd0);
        cyc(0, 0, 0, 1);
        chk("t1_addr1", last_addr, 32'd4);
        chk("t1_gap", {31'd0, out_valid}, 32'd0);
        cyc(0, 0, 0, 1);
        chk("t1_pc1", output_pc, 32'd8);
        chk("t1_ins1", output_instruction_memory, 32'hE000_0002);

        // back-pressure: five cycles stalled, accept on the sixth with same-cycle request
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("t2_req", {31'd0, last_req}, 32'd0);
            chk("t2_pc", output_pc, 32'd8);
            chk("t2_addr", imem_addr, 32'd8);
        end
        cyc(0, 0, 0, 1);
        chk("t2_acc_req", {31'd0, last_req}, 32'd1);
        chk("t2_acc_addr", last_addr, 32'd8);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);

        // freeze in REQ
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1);
            chk("t5_req", {31'd0, last_req}, 32'd0);
        end
        cyc(0, 0, 0, 1);
        chk("t5_addr", last_addr, 32'd12);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);

        // redirect while waiting on a slow response
        lat = 3;
        cyc(0, 0, 0, 1);
        cyc(1, 32'h100, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk("t3_novalid", {31'd0, out_valid}, 32'd0);
        lat = 0;
        cyc(0, 0, 0, 1);
        chk("t3_addr", last_addr, 32'h100);
        cyc(0, 0, 0, 1);
        chk("t3_pc", output_pc, 32'h104);
        cyc(0, 0, 1, 1);

        // redirect in the same cycle as the response
        cyc(0, 0, 0, 1);
        cyc(1, 32'h200, 0, 1);
        chk("t4_novalid", {31'd0, out_valid}, 32'd0);
        cyc(0, 0, 0, 1);
        chk("t4_addr", last_addr, 32'h200);
        cyc(0, 0, 0, 1);
        chk("t4_pc", output_pc, 32'h204);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            lat = $urandom_range(0, 3);
            cyc($urandom % 10 == 0,
                ($urandom % 8 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                $urandom % 4 == 0, $urandom % 4 != 0);
        end

        // asynchronous reset while holding an output
        lat = 0;
        for (int i = 0; i < 20 && q.size() == 0; i++) cyc(0, 0, 0, 0);
        chk("hold_reached", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_pc", output_pc, 32'd0);
        chk("arst_ins", output_instruction_memory, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc(0, 0, 0, 1);
        chk("arst_addr", last_addr, 32'd0);
        repeat (4) cyc(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage at the front of the pipeline; the producing end of the pc/instruction stream consumed by the downstream pipeline registers.
- Holds the program counter, issues one request at a time to instruction memory, and captures the response.
- Presents (pc, instruction) to the next stage with a valid/ready handshake.
- Handles branch redirect and hazard freeze.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment between sequential instructions

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
branch_taken  input  1  redirect request this cycle
branch_addr  input  32  redirect target
freeze  input  1  hazard stall; suppresses new memory requests
imem_req  output  1  memory request strobe, combinational
imem_addr  output  32  request address, equals pc_reg
imem_rsp_valid  input  1  response strobe; no fixed latency (>=1 cycle after req)
imem_rdata  input  32  instruction word, valid with imem_rsp_valid
out_valid  output  1  output pair valid
out_ready  input  1  downstream accepts
output_pc  output  32  fetched address + PC_STEP
output_instruction_memory  output  32  fetched instruction

Behaviour:
- Reset (rst=0, async):
  - pc_reg=RESET_PC, state=REQ, kill=0.
  - out_valid=0, output_pc=0, output_instruction_memory=0.
  - imem_req=0 while rst=0.
- States: REQ (ready to issue), WAIT (one request outstanding), HOLD (output valid, awaiting accept). At most one outstanding request.
- imem_req=1 when (state==REQ, or state==HOLD with out_ready=1) and freeze=0 and branch_taken=0.
- Issue rule: a request is issued in any cycle where imem_req=1; memory always accepts.
- REQ:
  - branch_taken: pc_reg<=branch_addr, stay REQ.
  - issue: go WAIT.
  - freeze without branch: stay REQ.
- WAIT, priority order:
  - imem_rsp_valid with kill=1: discard response, kill<=0, go REQ.
  - imem_rsp_valid with branch_taken: discard response, pc_reg<=branch_addr, go REQ.
  - imem_rsp_valid alone: output_instruction_memory<=imem_rdata, output_pc<=pc_reg+PC_STEP, pc_reg<=pc_reg+PC_STEP, out_valid<=1, go HOLD.
  - branch_taken without response: kill<=1, pc_reg<=branch_addr, stay WAIT.
  - freeze has no effect in WAIT; the response is still captured.
- HOLD (out_valid=1; outputs stable until accepted):
  - branch_taken: out_valid<=0, pc_reg<=branch_addr, go REQ. If out_ready=1 in that cycle, the transfer counts; the pair is never re-presented.
  - out_ready=1 with request issued: out_valid<=0, go WAIT.
  - out_ready=1 with freeze=1: out_valid<=0, go REQ.
  - out_ready=0: hold everything.
- Throughput: one instruction per 2 cycles with 1-cycle memory and out_ready held high.
- Arithmetic: pc addition is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Ignored inputs: imem_rsp_valid outside WAIT. branch_addr is unused unless branch_taken=1.
- When out_valid=0, output_pc and output_instruction_memory keep their last captured values.
- Reset mid-operation: all state returns to reset values immediately. A later response to a pre-reset request arrives while state is REQ and is ignored.

Test Plan:
- Reset release, 1-cycle memory returning 32'hE000_0001, 32'hE000_0002, out_ready=1 -> imem_addr 0,4; outputs (4,E0000001), then (8,E0000002); out_valid high every other cycle.
- out_ready=0 for 5 cycles while out_valid=1 -> output_pc/output_instruction_memory constant, imem_req=0, no pc_reg change; accept on cycle 6 -> next request to address 8 in that same cycle.
- branch_taken with branch_addr=32'h100 during WAIT, response 3 cycles later -> response discarded, out_valid stays 0, next imem_addr=32'h100, next output_pc=32'h104.
- branch_taken and imem_rsp_valid in the same cycle in WAIT -> response discarded, next request to branch_addr, no kill left set.
- freeze=1 for 4 cycles in REQ -> imem_req=0 throughout; freeze=0 -> request at unchanged pc.
- RESET_PC=32'hFFFF_FFFC, one fetch -> output_pc=0, next imem_addr=0. Separately, assert rst=0 while in HOLD -> out_valid=0 and output_pc=0 immediately, without waiting for a clock edge.
